// File: rtl/axi_rr_arb_slice.sv
// Round-robin arbiter with a single registered output slot for AXI channel trees.
// The priority pointer moves to the input after each winner and is exported as rr_flag_o.
module axi_rr_arb_slice #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_W      = $clog2(N_IN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IN-1:0]            in_valid_i,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data_i,
  output logic [N_IN-1:0]            in_ready_o,
  output logic                       out_valid_o,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic [SEL_W-1:0]           out_sel_o,
  input  logic                       out_ready_i,
  output logic [SEL_W-1:0]           rr_flag_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      rr_q;
  logic [SEL_W-1:0]      rr_d;

  logic                  accept;
  logic                  any_valid;
  logic                  handshake;
  logic                  found_hi;
  logic                  found_lo;
  logic [SEL_W-1:0]      win_hi;
  logic [SEL_W-1:0]      win_lo;
  logic [SEL_W-1:0]      win;
  logic [DATA_WIDTH-1:0] win_data;

  assign accept    = !valid_q | out_ready_i;
  assign any_valid = |in_valid_i;
  assign handshake = accept & any_valid;

  // Two scans: lowest valid index at or above the pointer, else lowest valid overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (!found_hi && in_valid_i[i] && (SEL_W'(i) >= rr_q)) begin
        found_hi = 1'b1;
        win_hi   = SEL_W'(i);
      end
      if (!found_lo && in_valid_i[i]) begin
        found_lo = 1'b1;
        win_lo   = SEL_W'(i);
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_data   = '0;
    in_ready_o = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (win == SEL_W'(i)) begin
        win_data      = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        in_ready_o[i] = rst_n & handshake;
      end
    end
  end

  // Explicit wrap keeps the pointer below N_IN for non-power-of-2 sizes.
  assign rr_d = (win == SEL_W'(N_IN - 1)) ? '0 : win + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
    end else if (handshake) begin
      valid_q <= 1'b1;
      data_q  <= win_data;
      sel_q   <= win;
      rr_q    <= rr_d;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_sel_o   = sel_q;
  assign rr_flag_o   = rr_q;

endmodule

// File: tb/tb_axi_rr_arb_slice.sv
// Scoreboard bench for axi_rr_arb_slice: a 4-input and a 3-input instance share stimulus,
// a behavioural model predicts grants and pointer, expected beats are queued and popped on drain.
module tb_axi_rr_arb_slice;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] word [4];
  logic [127:0] in_data;
  logic        out_ready;

  logic [3:0]  rdy4;
  logic        vld4;
  logic [31:0] dat4;
  logic [1:0]  sel4;
  logic [1:0]  rr4;
  logic [2:0]  rdy3;
  logic        vld3;
  logic [31:0] dat3;
  logic [1:0]  sel3;
  logic [1:0]  rr3;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit          use3;
  bit          m_valid;
  logic [1:0]  m_rr;
  logic [33:0] q [$];
  logic [33:0] last;

  always #5 clk = ~clk;

  assign in_data = {word[3], word[2], word[1], word[0]};

  axi_rr_arb_slice #(.N_IN(4), .DATA_WIDTH(32)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (rdy4),
    .out_valid_o (vld4),
    .out_data_o  (dat4),
    .out_sel_o   (sel4),
    .out_ready_i (out_ready),
    .rr_flag_o   (rr4)
  );

  axi_rr_arb_slice #(.N_IN(3), .DATA_WIDTH(32)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid[2:0]),
    .in_data_i   (in_data[95:0]),
    .in_ready_o  (rdy3),
    .out_valid_o (vld3),
    .out_data_o  (dat3),
    .out_sel_o   (sel3),
    .out_ready_i (out_ready),
    .rr_flag_o   (rr3)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0;
    m_rr    = 2'd0;
    q.delete();
    last    = '0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 4'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) word[i] = $urandom;
  endtask

  // One clock: drive, check combinational and registered outputs, advance model.
  task automatic cycle(input logic [3:0] v, input logic ordy, input logic rst, input bit rnd);
    int         nin;
    int         idx;
    bit         found;
    bit         hs;
    logic [1:0] w;
    logic [1:0] ix;
    logic [3:0] vm;
    logic [3:0] exp_rdy;
    logic [3:0] obs_rdy;
    logic       obs_vld;
    logic [31:0] obs_dat;
    logic [1:0] obs_sel;
    logic [1:0] obs_rr;
    logic [33:0] e;

    @(negedge clk);
    if (rnd) rand_words();
    nin       = use3 ? 3 : 4;
    vm        = use3 ? {1'b0, v[2:0]} : v;
    in_valid  = vm;
    out_ready = ordy;
    rst_n     = rst;
    #1;
    found = 1'b0;
    w     = 2'd0;
    for (int k = 0; k < nin; k++) begin
      idx = (int'(m_rr) + k) % nin;
      ix  = 2'(idx);
      if (!found && vm[ix]) begin
        found = 1'b1;
        w     = ix;
      end
    end
    hs      = rst && (!m_valid || ordy) && found;
    exp_rdy = hs ? (4'b0001 << w) : 4'b0000;

    obs_rdy = use3 ? {1'b0, rdy3} : rdy4;
    obs_vld = use3 ? vld3 : vld4;
    obs_dat = use3 ? dat3 : dat4;
    obs_sel = use3 ? sel3 : sel4;
    obs_rr  = use3 ? rr3 : rr4;

    check_eq("in_ready", obs_rdy, exp_rdy);
    check_eq("out_valid", obs_vld, m_valid);
    check_eq("rr_flag", obs_rr, m_rr);
    if (m_valid) begin
      check_eq("out_data", obs_dat, q[0][31:0]);
      check_eq("out_sel", obs_sel, q[0][33:32]);
    end else begin
      check_eq("hold_data", obs_dat, last[31:0]);
      check_eq("hold_sel", obs_sel, last[33:32]);
    end

    if (!rst) begin
      model_clear();
    end else begin
      if (m_valid && ordy) begin
        e    = q.pop_front();
        last = e;
      end
      if (hs) begin
        q.push_back({w, word[w]});
        m_valid = 1'b1;
        m_rr    = (int'(w) == nin - 1) ? 2'd0 : w + 2'd1;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    use3 = 1'b0;
    for (int i = 0; i < 4; i++) word[i] = 32'h1000_0000 + i;
    hard_reset();

    // Reset state and idle.
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // All valid, sink always ready: grants 0,1,2,3,0.
    repeat (5) cycle(4'b1111, 1'b1, 1'b1, 1'b1);

    // Pointer to 2, then only inputs 1 and 3 compete.
    cycle(4'b0010, 1'b1, 1'b1, 1'b1);
    cycle(4'b1010, 1'b1, 1'b1, 1'b1);
    cycle(4'b1010, 1'b1, 1'b1, 1'b1);

    // Stall with a known beat, then release with same-edge refill.
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    word[0] = 32'hDEAD_BEEF;
    cycle(4'b0001, 1'b1, 1'b1, 1'b0);
    repeat (5) cycle(4'b1111, 1'b0, 1'b1, 1'b1);
    cycle(4'b1111, 1'b1, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a stall.
    cycle(4'b0100, 1'b1, 1'b1, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Drain with no requesters: data and pointer hold.
    cycle(4'b0100, 1'b1, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1, 1'b1);

    repeat (40) cycle(4'($urandom), 1'($urandom), 1'b1, 1'b1);

    // Three-input instance: wrap from 2 to 0, lone requester on 0.
    use3 = 1'b1;
    hard_reset();
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    cycle(4'b0100, 1'b1, 1'b1, 1'b1);
    repeat (4) cycle(4'b0001, 1'b1, 1'b1, 1'b1);
    repeat (3) cycle(4'b0111, 1'b1, 1'b1, 1'b1);
    repeat (40) cycle(4'($urandom), 1'($urandom), 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
